// File: rtl/muldiv_issue_client_pkg.sv
// Shared types for the mul/div issue clients and the locked mul/div array.
package muldiv_issue_client_pkg;

  localparam int XLEN = 32;

  // Operation codes understood by every MDU in the array.
  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_operation_t;

  // Request towards one array port.
  typedef struct packed {
    mdu_operation_t  op;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            start;
  } muldiv_req_t;

  // Answer from one array port; data is meaningful once busy has fallen.
  typedef struct packed {
    logic            busy;
    logic [XLEN-1:0] data;
  } muldiv_ans_t;

  // Client sequencer states. DRAIN is encoded for a future policy and is
  // never entered today.
  typedef enum logic [2:0] {
    MDC_IDLE  = 3'd0,
    MDC_ACQ   = 3'd1,
    MDC_START = 3'd2,
    MDC_WAIT  = 3'd3,
    MDC_DONE  = 3'd4,
    MDC_DRAIN = 3'd5
  } mdc_state_e;

  // The lock request is asserted while acquiring or holding the MDU.
  function automatic logic holds_lock(mdc_state_e s);
    return (s == MDC_ACQ) || (s == MDC_START) || (s == MDC_WAIT);
  endfunction

endpackage

// File: rtl/muldiv_issue_client.sv
// Per-port sequencer in front of the locked mul/div array: accepts one op,
// acquires an MDU through the resource-pool lock, pulses start, waits out
// busy, captures the result, releases the lock and hands the result back
// over a valid/ready interface.
//
// The lock request port rpl packs {req, id}: rpl[ID_WIDTH] is req and
// rpl[ID_WIDTH-1:0] is the owner id (always PORT_ID).
// TIMEOUT_CYCLES must be at least 16 so a healthy MDU never trips the watchdog.
module muldiv_issue_client
  import muldiv_issue_client_pkg::*;
#(
  parameter int ID_WIDTH       = 16,
  parameter int PORT_ID        = 0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  mdu_operation_t      in_op,
  input  logic [XLEN-1:0]     in_op1,
  input  logic [XLEN-1:0]     in_op2,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_data,
  output logic                err,
  output logic [ID_WIDTH:0]   rpl,
  output muldiv_req_t         mreq,
  input  muldiv_ans_t         mans,
  input  logic                grant
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  // A WAIT cycle that starts with this count brings the counter to
  // TIMEOUT_CYCLES, i.e. it is the last cycle the watchdog tolerates.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_WIDTH-1:0] OWNER_ID = ID_WIDTH'(PORT_ID);

  mdc_state_e      state_q, state_d;
  mdu_operation_t  op_q;
  logic [XLEN-1:0] op1_q, op2_q;
  logic [CNT_W-1:0] cnt_q;
  logic            killed_q;
  logic [XLEN-1:0] out_data_q;
  logic            err_q;

  // Datapath control decoded by the FSM.
  logic latch_op;
  logic cnt_clr, cnt_inc;
  logic kill_set, kill_clr;
  logic cap_mdu, cap_zero;
  logic err_set;
  logic mdu_finished;

  // The first WAIT cycle (count 0) ignores busy: the unit raises busy only
  // the cycle after start, so busy=0 there says nothing about completion.
  assign mdu_finished = (cnt_q != '0) && !mans.busy;

  // Next-state and datapath-control decode.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    state_d  = state_q;
    latch_op = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    kill_set = 1'b0;
    kill_clr = 1'b0;
    cap_mdu  = 1'b0;
    cap_zero = 1'b0;
    err_set  = 1'b0;

    unique case (state_q)
      MDC_IDLE: begin
        // in_ready is high here, so in_valid alone completes the handshake.
        if (in_valid) begin
          latch_op = 1'b1;
          kill_clr = 1'b1;
          state_d  = MDC_ACQ;
        end
      end

      MDC_ACQ: begin
        // Nothing has been issued yet, so a flush simply abandons the request.
        if (flush) begin
          state_d = MDC_IDLE;
        end else if (grant) begin
          state_d = MDC_START;
        end
      end

      MDC_START: begin
        cnt_clr = 1'b1;
        if (flush) kill_set = 1'b1;
        if (!grant) err_set = 1'b1;
        state_d = MDC_WAIT;
      end

      MDC_WAIT: begin
        cnt_inc = 1'b1;
        if (flush) kill_set = 1'b1;
        if (!grant) err_set = 1'b1;
        if (mdu_finished) begin
          cap_mdu = 1'b1;
          // A kill (earlier or this very cycle) discards the result.
          state_d = (killed_q || flush) ? MDC_IDLE : MDC_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_set  = 1'b1;
          cap_zero = 1'b1;
          state_d  = (killed_q || flush) ? MDC_IDLE : MDC_DONE;
        end
      end

      MDC_DONE: begin
        // flush wins over out_ready: the result counts as not consumed.
        if (flush || out_ready) state_d = MDC_IDLE;
      end

      default: begin
        state_d = MDC_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q <= MDC_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand latch, wait counter, kill flag, result and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= MDU_MUL;
      op1_q      <= '0;
      op2_q      <= '0;
      cnt_q      <= '0;
      killed_q   <= 1'b0;
      out_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (latch_op) begin
        op_q  <= in_op;
        op1_q <= in_op1;
        op2_q <= in_op2;
      end

      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_inc && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (kill_clr) begin
        killed_q <= 1'b0;
      end else if (kill_set) begin
        killed_q <= 1'b1;
      end

      if (cap_mdu) begin
        out_data_q <= mans.data;
      end else if (cap_zero) begin
        out_data_q <= '0;
      end

      if (err_set) err_q <= 1'b1;
    end
  end

  // Output decode; operands stay stable from START until the lock is released.
  always_comb begin
    in_ready   = (state_q == MDC_IDLE);
    out_valid  = (state_q == MDC_DONE);
    out_data   = out_data_q;
    err        = err_q;
    rpl        = {holds_lock(state_q), OWNER_ID};
    mreq.op    = op_q;
    mreq.op1   = op1_q;
    mreq.op2   = op2_q;
    mreq.start = (state_q == MDC_START);
  end

endmodule

// File: tb/tb_muldiv_issue_client.sv
// Bench for muldiv_issue_client: two clients share one behavioural MDU
// behind a behavioural lock arbiter. A scoreboard of hand-computed results
// is checked on every handshake, with per-cycle protocol invariants.
`timescale 1ns/1ps
module tb_muldiv_issue_client;
  import muldiv_issue_client_pkg::*;

  localparam int IDW = 16;
  localparam int TMO = 16;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  int n_checks = 0;
  int n_errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic           in_valid [2];
  mdu_operation_t in_op    [2];
  logic [31:0]    in_op1   [2];
  logic [31:0]    in_op2   [2];
  logic           flush    [2];
  logic           out_ready[2];
  logic           grant    [2];

  logic           in_ready0, in_ready1, out_valid0, out_valid1, err0, err1;
  logic [31:0]    out_data0, out_data1;
  logic [IDW:0]   rpl0, rpl1;
  muldiv_req_t    mreq0, mreq1;
  muldiv_ans_t    mans;

  muldiv_issue_client #(.ID_WIDTH(IDW), .PORT_ID(0), .TIMEOUT_CYCLES(TMO)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready0),
    .in_op(in_op[0]), .in_op1(in_op1[0]), .in_op2(in_op2[0]), .flush(flush[0]),
    .out_valid(out_valid0), .out_ready(out_ready[0]), .out_data(out_data0),
    .err(err0), .rpl(rpl0), .mreq(mreq0), .mans(mans), .grant(grant[0])
  );

  muldiv_issue_client #(.ID_WIDTH(IDW), .PORT_ID(1), .TIMEOUT_CYCLES(TMO)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready1),
    .in_op(in_op[1]), .in_op1(in_op1[1]), .in_op2(in_op2[1]), .flush(flush[1]),
    .out_valid(out_valid1), .out_ready(out_ready[1]), .out_data(out_data1),
    .err(err1), .rpl(rpl1), .mreq(mreq1), .mans(mans), .grant(grant[1])
  );

  // Indexed views of the DUT outputs.
  logic        o_rdy[2], o_vld[2], o_err[2], o_req[2], o_start[2];
  logic [31:0] o_data[2];
  always_comb begin
    o_rdy[0] = in_ready0;   o_rdy[1] = in_ready1;
    o_vld[0] = out_valid0;  o_vld[1] = out_valid1;
    o_err[0] = err0;        o_err[1] = err1;
    o_req[0] = rpl0[IDW];   o_req[1] = rpl1[IDW];
    o_start[0] = mreq0.start; o_start[1] = mreq1.start;
    o_data[0] = out_data0;  o_data[1] = out_data1;
  end

  // ---------------- lock arbiter model (owner 2 = free, port 0 first) ----
  logic [1:0] owner;
  logic       grant_kill;
  logic       g_raw[2];
  always_comb begin
    g_raw[0] = o_req[0] && (owner == 2'd0 || owner == 2'd2);
    g_raw[1] = o_req[1] && (owner == 2'd1 || (owner == 2'd2 && !o_req[0]));
    grant[0] = g_raw[0] && !grant_kill;
    grant[1] = g_raw[1];
  end
  always @(posedge clk) begin
    if (reset) owner <= 2'd2;
    else if (owner == 2'd2) begin
      if (g_raw[0]) owner <= 2'd0;
      else if (g_raw[1]) owner <= 2'd1;
    end else if (!o_req[owner[0]]) owner <= 2'd2;
  end

  // ---------------- MDU model ---------------------------------------------
  function automatic logic [31:0] mdu_compute(mdu_operation_t op, logic [31:0] a, logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
    ua = {32'b0, a};       ub = {32'b0, b};
    case (op)
      MDU_MUL:    begin p = ua * ub; return p[31:0];  end
      MDU_MULH:   begin p = sa * sb; return p[63:32]; end
      MDU_MULHSU: begin p = sa * ub; return p[63:32]; end
      MDU_MULHU:  begin p = ua * ub; return p[63:32]; end
      MDU_DIV:    if (b == 0) return 32'hFFFF_FFFF;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                  else return 32'($signed(a) / $signed(b));
      MDU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MDU_REM:    if (b == 0) return a;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                  else return 32'($signed(a) % $signed(b));
      default:    return (b == 0) ? a : a % b;
    endcase
  endfunction

  int          mdu_lat;
  logic        mdu_stuck;
  logic        mdu_busy;
  int          mdu_cnt;
  logic [31:0] mdu_res, mdu_data;
  int          mdu_starts = 0;
  int          mdu_owner = 0;
  always_comb begin
    mans.busy = mdu_busy;
    mans.data = mdu_data;
  end
  always @(posedge clk) begin
    if (reset) begin
      mdu_busy <= 1'b0; mdu_cnt <= 0; mdu_data <= '0; mdu_res <= '0;
    end else if (o_start[0] || o_start[1]) begin
      mdu_busy   <= 1'b1;
      mdu_cnt    <= mdu_lat;
      mdu_owner  <= o_start[1] ? 1 : 0;
      mdu_res    <= o_start[1] ? mdu_compute(mreq1.op, mreq1.op1, mreq1.op2)
                               : mdu_compute(mreq0.op, mreq0.op1, mreq0.op2);
      mdu_starts <= mdu_starts + 1;
    end else if (mdu_busy && !mdu_stuck) begin
      if (mdu_cnt <= 1) begin
        mdu_busy <= 1'b0;
        mdu_data <= mdu_res;
      end
      mdu_cnt <= mdu_cnt - 1;
    end
  end

  // ---------------- checking ----------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  exp_t q0[$];
  exp_t q1[$];

  task automatic push_exp(input int p, input logic [31:0] d, input logic e);
    exp_t x;
    x.data = d; x.err = e;
    if (p == 0) q0.push_back(x); else q1.push_back(x);
  endtask

  logic        pv_vld[2], pv_rdy[2], pv_flush[2];
  logic [31:0] pv_data[2];
  logic        lock_chk_en;

  task automatic score(input int p);
    exp_t e;
    int   sz;
    sz = (p == 0) ? q0.size() : q1.size();
    if (o_vld[p] && out_ready[p] && !flush[p]) begin
      if (sz == 0) begin
        check($sformatf("p%0d_unexpected_result", p), o_vld[p], 0);
      end else begin
        e = (p == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("p%0d_result_data", p), o_data[p], e.data);
        check($sformatf("p%0d_result_err", p), o_err[p], e.err);
      end
    end
    if (pv_vld[p] && !pv_rdy[p] && !pv_flush[p]) begin
      check($sformatf("p%0d_valid_held", p), o_vld[p], 1);
      check($sformatf("p%0d_data_stable", p), o_data[p], pv_data[p]);
    end
    check($sformatf("p%0d_ready_and_valid", p), o_rdy[p] & o_vld[p], 0);
    check($sformatf("p%0d_ready_and_req", p), o_rdy[p] & o_req[p], 0);
    if (o_start[p]) check($sformatf("p%0d_start_has_grant", p), grant[p], 1);
    pv_vld[p] = o_vld[p]; pv_rdy[p] = out_ready[p];
    pv_flush[p] = flush[p]; pv_data[p] = o_data[p];
  endtask

  // Per-cycle compare against the scoreboard and protocol rules.
  always @(negedge clk) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) pv_vld[p] = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) score(p);
      check("start_overlap", o_start[0] & o_start[1], 0);
      if (o_start[0] || o_start[1]) check("start_while_busy", mans.busy, 0);
      if (lock_chk_en && mans.busy) check("lock_held_while_busy", o_req[mdu_owner], 1);
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input int p, input mdu_operation_t op, input logic [31:0] a, input logic [31:0] b);
    int t = 0;
    while (!o_rdy[p] && t < 100) begin tick(); t++; end
    check($sformatf("p%0d_issue_ready", p), o_rdy[p], 1);
    in_valid[p] = 1'b1; in_op[p] = op; in_op1[p] = a; in_op2[p] = b;
    tick();
    in_valid[p] = 1'b0;
  endtask

  task automatic wait_valid(input int p, input int budget, output int lat);
    lat = 0;
    while (!o_vld[p] && lat < budget) begin tick(); lat++; end
    if (!o_vld[p]) check($sformatf("p%0d_valid_timeout", p), o_vld[p], 1);
  endtask

  task automatic wait_start(input int p);
    int t = 0;
    while (!o_start[p] && t < 50) begin tick(); t++; end
    if (!o_start[p]) check($sformatf("p%0d_start_timeout", p), o_start[p], 1);
  endtask

  task automatic reset_checks(input int p, input string tag);
    check($sformatf("%s_p%0d_in_ready", tag, p), o_rdy[p], 1);
    check($sformatf("%s_p%0d_out_valid", tag, p), o_vld[p], 0);
    check($sformatf("%s_p%0d_out_data", tag, p), o_data[p], 0);
    check($sformatf("%s_p%0d_err", tag, p), o_err[p], 0);
    check($sformatf("%s_p%0d_req", tag, p), o_req[p], 0);
    check($sformatf("%s_p%0d_mreq_zero", tag, p), (p == 0) ? (mreq0 == '0) : (mreq1 == '0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- directed tests ----------------------------------------
  initial begin
    int lat, s0, t;
    logic seen;
    reset = 1'b1;
    for (int p = 0; p < 2; p++) begin
      in_valid[p] = 0; in_op[p] = MDU_MUL; in_op1[p] = 0; in_op2[p] = 0;
      flush[p] = 0; out_ready[p] = 1; pv_vld[p] = 0; pv_rdy[p] = 0;
      pv_flush[p] = 0; pv_data[p] = 0;
    end
    mdu_lat = 5; mdu_stuck = 0; grant_kill = 0; lock_chk_en = 1;
    repeat (3) @(posedge clk);
    #1;
    reset_checks(0, "por");
    reset_checks(1, "por");
    reset = 1'b0;
    tick();

    // 1: MUL 7*6, busy 5 cycles.
    mdu_lat = 5; s0 = mdu_starts;
    push_exp(0, 32'd42, 1'b0);
    issue(0, MDU_MUL, 32'd7, 32'd6);
    wait_valid(0, 50, lat);
    check("t1_latency", lat, 8);
    check("t1_data", out_data0, 32'd42);
    check("t1_err", err0, 0);
    check("t1_req_released", o_req[0], 0);
    check("t1_single_start", mdu_starts - s0, 1);
    tick();

    // 1b: minimum latency, DIVU by zero.
    mdu_lat = 1;
    push_exp(0, 32'hFFFF_FFFF, 1'b0);
    issue(0, MDU_DIVU, 32'd9, 32'd0);
    wait_valid(0, 50, lat);
    check("t1b_min_latency", lat, 4);
    check("t1b_div_by_zero", out_data0, 32'hFFFF_FFFF);
    tick();

    // 2: two clients contend for one MDU.
    mdu_lat = 3; s0 = mdu_starts;
    push_exp(0, 32'd132, 1'b0);
    push_exp(1, 32'd125, 1'b0);
    in_valid[0] = 1; in_op[0] = MDU_MUL; in_op1[0] = 32'd12;   in_op2[0] = 32'd11;
    in_valid[1] = 1; in_op[1] = MDU_DIV; in_op1[1] = 32'd1000; in_op2[1] = 32'd8;
    tick();
    in_valid[0] = 0; in_valid[1] = 0;
    wait_valid(0, 50, lat);
    check("t2_p1_still_requesting", o_req[1], 1);
    check("t2_p1_not_ready", o_rdy[1], 0);
    check("t2_p1_no_result_yet", o_vld[1], 0);
    wait_valid(1, 50, lat);
    check("t2_p1_data", out_data1, 32'd125);
    check("t2_two_starts", mdu_starts - s0, 2);
    tick();

    // 3: flush two cycles into WAIT of DIV 100/7.
    mdu_lat = 8;
    issue(0, MDU_DIV, 32'd100, 32'd7);
    wait_start(0);
    tick(); tick();
    flush[0] = 1; tick(); flush[0] = 0;
    seen = 0; t = 0;
    while (!o_rdy[0] && t < 40) begin
      if (o_vld[0]) seen = 1;
      tick(); t++;
    end
    check("t3_back_to_idle", o_rdy[0], 1);
    check("t3_no_out_valid", seen, 0);
    check("t3_mdu_idle_at_release", mans.busy, 0);
    check("t3_mdu_quotient", mdu_data, 32'd14);
    push_exp(0, 32'd15, 1'b0);
    issue(0, MDU_MUL, 32'd3, 32'd5);
    wait_valid(0, 50, lat);
    check("t3_next_op_data", out_data0, 32'd15);
    tick();

    // 5: consumer stalls 10 cycles in DONE.
    mdu_lat = 2;
    out_ready[0] = 0;
    push_exp(0, 32'hFFFF_FFFE, 1'b0);
    issue(0, MDU_MUL, 32'hFFFF_FFFF, 32'd2);
    wait_valid(0, 50, lat);
    for (int i = 0; i < 10; i++) begin
      check("t5_valid_held", o_vld[0], 1);
      check("t5_data_held", out_data0, 32'hFFFF_FFFE);
      check("t5_in_ready_low", o_rdy[0], 0);
      tick();
    end
    out_ready[0] = 1;
    tick();
    check("t5_consumed", o_vld[0], 0);
    check("t5_idle_again", o_rdy[0], 1);

    // 4: busy stuck high, watchdog after 16 WAIT cycles.
    mdu_lat = 2; mdu_stuck = 1; lock_chk_en = 0;
    push_exp(0, 32'd0, 1'b1);
    issue(0, MDU_MUL, 32'd2, 32'd3);
    lat = 0;
    while (!o_vld[0] && lat < 60) begin
      if (lat == 16) check("t4_no_err_before_timeout", err0, 0);
      tick(); lat++;
    end
    check("t4_latency", lat, 18);
    check("t4_err", err0, 1);
    check("t4_data_zero", out_data0, 0);
    check("t4_lock_released", o_req[0], 0);
    tick();
    mdu_stuck = 0; t = 0;
    while (mans.busy && t < 20) begin tick(); t++; end
    lock_chk_en = 1;

    // 6: reset in WAIT.
    mdu_lat = 6;
    issue(0, MDU_DIVU, 32'd50, 32'd5);
    wait_start(0);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset_checks(0, "t6");
    reset = 1'b0;
    tick();
    push_exp(0, 32'd81, 1'b0);
    issue(0, MDU_MUL, 32'd9, 32'd9);
    wait_valid(0, 50, lat);
    check("t6_new_op_data", out_data0, 32'd81);
    check("t6_new_op_err", err0, 0);
    tick();

    // 7: grant lost during WAIT flags err but still completes.
    mdu_lat = 4;
    push_exp(0, 32'd20, 1'b1);
    issue(0, MDU_MUL, 32'd4, 32'd5);
    wait_start(0);
    tick();
    grant_kill = 1; tick(); grant_kill = 0;
    wait_valid(0, 50, lat);
    check("t7_data", out_data0, 32'd20);
    check("t7_err", err0, 1);
    tick();

    repeat (3) tick();
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
